// File: rtl/function_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : function_generator_pkg
//  Description : Shared widths, digit type and converter FSM states for the
//                binary-to-BCD display path.
//  Revision    : 1.0  initial release
// ============================================================================
package function_generator_pkg;

  // Binary word width and number of decimal digits on the front panel
  localparam int BIN_WIDTH  = 23;
  localparam int BCD_DIGITS = 7;

  // One packed BCD digit
  typedef logic [3:0] bcd_digit_t;

  // Converter control states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_e;

endpackage : function_generator_pkg
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adjust
//  Description : Double-dabble correction for one BCD digit. A digit of 5 or
//                more gets 3 added so the following left shift carries
//                correctly into the next decimal place.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_adjust
  import function_generator_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  // Add 3 when the digit would reach 10 or more after doubling. Inputs are
  // always 0..9 during a conversion, so the result (max 12) fits in 4 bits.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/binary_to_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_bcd_converter
//  Description : Sequential double-dabble converter. Turns an unsigned
//                WIDTH-bit word into DIGITS BCD digits, one bit per clock,
//                with a start / busy / done handshake. Output digits are
//                registered and only change on the done cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module binary_to_bcd_converter
  import function_generator_pkg::*;
#(
  parameter int WIDTH  = BIN_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       d_1,
  output logic [3:0]       d_2,
  output logic [3:0]       d_3,
  output logic [3:0]       d_4,
  output logic [3:0]       d_5,
  output logic [3:0]       d_6,
  output logic [3:0]       d_7
);

  // Counter must hold the value WIDTH itself
  localparam int               CNT_WIDTH = $clog2(WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);
  localparam int               BCD_BITS  = 4 * DIGITS;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  conv_state_e           state_q,   state_d;
  logic [WIDTH-1:0]      bin_q,     bin_d;
  logic [BCD_BITS-1:0]   scratch_q, scratch_d;
  logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
  logic [BCD_BITS-1:0]   digits_q,  digits_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;

  // Scratch after per-digit correction, and the combined shift result
  logic [BCD_BITS-1:0]       scratch_adj;
  logic [BCD_BITS+WIDTH-1:0] shifted;

  // --------------------------------------------------------------------------
  // Per-digit add-3 correction on the scratch register
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
      bcd_digit_adjust u_adjust (
        .digit_in  (scratch_q[4*gi +: 4]),
        .digit_out (scratch_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Shift the corrected scratch and the binary register left as one vector;
  // the binary MSB moves into the scratch LSB.
  always_comb begin
    shifted = {scratch_adj, bin_q} << 1;
  end

  // --------------------------------------------------------------------------
  // Next-state logic for the FSM, datapath and registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A start here is accepted even during the done pulse, giving one
        // conversion per WIDTH+1 cycles when start is held.
        if (start) begin
          bin_d     = value_in;
          scratch_d = '0;
          cnt_d     = CNT_LOAD;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // start is deliberately ignored while a conversion is running
        scratch_d = shifted[BCD_BITS+WIDTH-1 -: BCD_BITS];
        bin_d     = shifted[WIDTH-1:0];
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Last bit shifted in: publish the finished digits
          digits_d = shifted[BCD_BITS+WIDTH-1 -: BCD_BITS];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers with asynchronous active-low reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: straight from registers, d_1 is the units digit
  // --------------------------------------------------------------------------
  assign busy = busy_q;
  assign done = done_q;
  assign d_1  = digits_q[ 3: 0];
  assign d_2  = digits_q[ 7: 4];
  assign d_3  = digits_q[11: 8];
  assign d_4  = digits_q[15:12];
  assign d_5  = digits_q[19:16];
  assign d_6  = digits_q[23:20];
  assign d_7  = digits_q[27:24];

endmodule : binary_to_bcd_converter
`default_nettype wire

// File: tb/tb_binary_to_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_binary_to_bcd_converter
//  Description : Directed self-checking bench for binary_to_bcd_converter.
//                Expected digit strings are written as hex so each nibble
//                reads as the decimal digit it should hold.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_binary_to_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [22:0] value_in;
  logic        busy;
  logic        done;
  logic [3:0]  d_1, d_2, d_3, d_4, d_5, d_6, d_7;
  logic [27:0] digits;

  int checks;
  int errors;

  binary_to_bcd_converter #(
    .WIDTH  (23),
    .DIGITS (7)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value_in (value_in),
    .busy     (busy),
    .done     (done),
    .d_1      (d_1),
    .d_2      (d_2),
    .d_3      (d_3),
    .d_4      (d_4),
    .d_5      (d_5),
    .d_6      (d_6),
    .d_7      (d_7)
  );

  assign digits = {d_7, d_6, d_5, d_4, d_3, d_2, d_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check_equal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one conversion and check latency, done pulse and result
  task automatic run_conv(input logic [22:0] val, input logic [27:0] exp_bcd, input string tag);
    int n;
    int early_done;
    start    = 1'b1;
    value_in = val;
    tick();
    start    = 1'b0;
    value_in = '0;
    check_equal({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
    n = 0;
    early_done = 0;
    while (busy && n < 40) begin
      if (done) early_done++;
      tick();
      n++;
    end
    check_equal({tag, "_busy_cycles"}, n, 32'd23);
    check_equal({tag, "_early_done"}, early_done, 32'd0);
    check_equal({tag, "_done"}, {31'd0, done}, 32'd1);
    check_equal({tag, "_digits"}, {4'd0, digits}, {4'd0, exp_bcd});
    tick();
    check_equal({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    check_equal({tag, "_digits_hold"}, {4'd0, digits}, {4'd0, exp_bcd});
  endtask

  initial begin
    int n;
    int pulses;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    value_in = '0;

    // Reset state
    #12;
    check_equal("reset_busy",   {31'd0, busy}, 32'd0);
    check_equal("reset_done",   {31'd0, done}, 32'd0);
    check_equal("reset_digits", {4'd0, digits}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic conversions
    run_conv(23'd0,       28'h0000000, "zero");
    run_conv(23'd1234567, 28'h1234567, "mid");
    run_conv(23'd8388607, 28'h8388607, "max");
    run_conv(23'd9,       28'h0000009, "nine");

    // start during busy is ignored
    start    = 1'b1;
    value_in = 23'd1000;
    tick();
    start    = 1'b0;
    value_in = '0;
    n = 0;
    while (busy && n < 40) begin
      if (n == 10) begin
        start    = 1'b1;
        value_in = 23'd5;
      end else begin
        start    = 1'b0;
        value_in = '0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check_equal("ign_busy_cycles", n, 32'd23);
    check_equal("ign_done", {31'd0, done}, 32'd1);
    check_equal("ign_digits", {4'd0, digits}, 32'h0001000);
    tick();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    check_equal("ign_no_second", pulses, 32'd0);
    check_equal("ign_digits_hold", {4'd0, digits}, 32'h0001000);

    // start held high: one result every 24 cycles
    start    = 1'b1;
    value_in = 23'd999999;
    tick();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      while (!done && n < 60) begin
        tick();
        n++;
      end
      check_equal($sformatf("held_period%0d", k), n, (k == 0) ? 32'd23 : 32'd24);
      check_equal($sformatf("held_digits%0d", k), {4'd0, digits}, 32'h0999999);
      if (k == 2) start = 1'b0;
      tick();
      n = 1;
      check_equal($sformatf("held_pulse%0d", k), {31'd0, done}, 32'd0);
    end
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    tick();

    // Reset in the middle of a conversion
    start    = 1'b1;
    value_in = 23'd4194304;
    tick();
    start    = 1'b0;
    value_in = '0;
    for (int i = 0; i < 12; i++) tick();
    check_equal("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_equal("rst_mid_busy",   {31'd0, busy}, 32'd0);
    check_equal("rst_mid_done",   {31'd0, done}, 32'd0);
    check_equal("rst_mid_digits", {4'd0, digits}, 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) pulses++;
      tick();
    end
    check_equal("rst_mid_no_done", pulses, 32'd0);
    run_conv(23'd42, 28'h0000042, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_binary_to_bcd_converter
`default_nettype wire

// File: doc/binary_to_bcd_converter.md
Name: binary_to_bcd_converter

Overview:
- Sequential double-dabble converter: 23-bit unsigned binary value to 7 BCD digits (d_1 = units … d_7 = millions).
- Inverse of the front-panel BCD-to-binary path. Turns the internal frequency/amplitude word back into digits for the 7-segment display and digit-editing logic.
- Start/done handshake, one bit per clock. Area is small; latency is not critical.

Parameters:
- WIDTH, 23, binary input width. Constraint: 2^WIDTH-1 <= 10^DIGITS-1.
- DIGITS, 7, number of BCD output digits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion; sampled only in IDLE
- value_in  input  WIDTH  unsigned binary, captured on accepted start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when d_1..d_7 carry the new result
- d_1..d_7  output  4 each  BCD digits, d_1 least significant, registered

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, d_1..d_7=0, shift register=0, bit counter=0. Deassertion is synchronised externally.
- FSM states: IDLE, SHIFT.
- IDLE:
  - done is driven 0 except during the pulse cycle defined below.
  - On the rising edge where start=1: load the binary shift register with value_in, clear the BCD scratch register (4*DIGITS bits), set counter=WIDTH, go to SHIFT, busy=1.
- SHIFT, each edge:
  - For every scratch digit >=5, add 3 (combinational adjust).
  - Shift {bcd_scratch, bin_reg} left by 1.
  - Decrement counter.
  - When counter goes 1->0 on this edge: copy the adjusted-and-shifted scratch into d_1..d_7, set done=1, busy=0, go to IDLE.
- Latency:
  - busy is high for exactly WIDTH (23) cycles after the start edge.
  - done is high in the cycle following the 23rd shift edge, for exactly one cycle.
  - New digits are valid in the same cycle as done.
- start while busy: ignored, not queued.
- start in the done cycle: accepted, since the FSM is already in IDLE. Back-to-back conversions are therefore one per 24 cycles.
- d_1..d_7 hold the last result until the next done. They never show intermediate scratch values.
- value_in is don't-care outside the accepting edge.
- Arithmetic:
  - Digit adjust is 4-bit and never overflows (max 9+3 before shift).
  - No overflow exists for WIDTH=23: 8,388,607 < 9,999,999.
  - Counter width = clog2(WIDTH+1).
- Reset mid-conversion: immediate return to reset values. d_* are cleared to 0 and no done is issued.

Decomposition:
- Shared package (function_generator_pkg):
  - BIN_WIDTH=23, BCD_DIGITS=7.
  - bcd_digit_t (4-bit) typedef.
  - FSM state enum {IDLE, SHIFT}.
- Sub-module bcd_digit_adjust: combinational, 4-bit in and 4-bit out, add 3 when input >=5. Instantiated DIGITS times via generate.

Test Plan:
- Reset then start, value_in=0 -> busy high 23 cycles, done pulse on cycle 24, all digits 0.
- value_in=1234567 -> d_7..d_1 = 1,2,3,4,5,6,7; done exactly one cycle.
- value_in=8388607 (all ones) -> digits 8,3,8,8,6,0,7. Then value_in=9 -> d_1=9, others 0.
- value_in=1000 started; start pulsed with value_in=5 at cycle 10 of busy -> result still 1000 (d_4=1, others 0); no second done.
- start held high continuously with value_in=999999 -> done every 24 cycles. Each result 0,9,9,9,9,9,9 (d_7..d_1).
- value_in=4194304 started, rst_n low at cycle 12 -> busy=0, done=0, digits 0 immediately. After release, new start with 42 -> d_2=4, d_1=2.
